// File: rtl/pc_sequencer_ctx_if.sv
// Control-unit <-> PC sequencer signal bundle; clock and reset stay outside as plain ports.
// master = control unit / scheduler side, slave = sequencer.
interface pc_sequencer_ctx_if #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 11,
  parameter int PID_W  = 2
);
  logic              halt_req;
  logic              branch_take;
  logic              jump_en;
  logic              jump_reg_en;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] rs_val;
  logic              ctx_en;
  logic              ctx_ret;
  logic [PID_W-1:0]  next_pid;
  logic              io_trap;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [PID_W-1:0]  cur_pid;
  logic              in_sched;
  logic              in_io;

  modport master (
    output halt_req, branch_take, jump_en, jump_reg_en, imm, rs_val,
           ctx_en, ctx_ret, next_pid, io_trap,
    input  pc, pc_plus1, cur_pid, in_sched, in_io
  );

  modport slave (
    input  halt_req, branch_take, jump_en, jump_reg_en, imm, rs_val,
           ctx_en, ctx_ret, next_pid, io_trap,
    output pc, pc_plus1, cur_pid, in_sched, in_io
  );
endinterface

// File: rtl/pc_sequencer_ctx.sv
// PC sequencer with quantum preemption and a per-process saved-PC table; IO trap enabled by PCSEQ_IO_TRAP_EN.
// Latency: new pc visible one cycle after the decision; pc_plus1 is combinational.
// Backpressure: none; halt_req freezes pc, state, timer, table and pid and masks every other input.
module pc_sequencer_ctx #(
  parameter int ADDR_W      = 32,
  parameter int IMM_W       = 11,
  parameter int JR_W        = 26,
  parameter int NPROC       = 4,
  parameter int QUANTUM     = 1024,
  parameter int SCHED_ADDR  = 0,
  parameter int IO_ADDR     = 512,
  parameter int PROC_STRIDE = 1024
) (
  input logic               clock,
  input logic               reset,
  pc_sequencer_ctx_if.slave bus
);
  localparam int PID_W = (NPROC > 1) ? $clog2(NPROC) : 1;
  localparam int QW    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

  typedef enum logic [1:0] {RUN, SCHED, IOSVC} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] seq_next, pc_plus1;
  logic [PID_W-1:0]  pid_q, pid_d, np_eff;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic [ADDR_W-1:0] saved_q [NPROC];
  logic [ADDR_W-1:0] saved_d [NPROC];
  logic              q_trap;
  logic              io_take;

  always_comb begin
    pc_plus1 = pc_q + ADDR_W'(1);
    if (bus.jump_en) begin
      if (bus.jump_reg_en) seq_next = {pc_q[ADDR_W-1:JR_W], bus.rs_val[JR_W-1:0]};
      else                 seq_next = {pc_q[ADDR_W-1:IMM_W], bus.imm};
    end else if (bus.branch_take) begin
      seq_next = {pc_q[ADDR_W-1:IMM_W], bus.imm};
    end else begin
      seq_next = pc_plus1;
    end
  end

  // Out-of-range pids from the scheduler fall back to process 0.
  assign np_eff = (32'(bus.next_pid) < NPROC) ? bus.next_pid : '0;

`ifdef PCSEQ_IO_TRAP_EN
  assign io_take   = bus.io_trap;
  assign bus.in_io = (state_q == IOSVC);
`else
  logic unused_io;
  assign unused_io = bus.io_trap;
  assign io_take   = 1'b0;
  assign bus.in_io = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pid_d   = pid_q;
    qcnt_d  = qcnt_q;
    saved_d = saved_q;
    q_trap  = (qcnt_q == QMAX) && bus.ctx_en;
    if (!bus.halt_req) begin
      case (state_q)
        RUN: begin
          if (q_trap) begin
            saved_d[pid_q] = seq_next;
            pc_d           = ADDR_W'(SCHED_ADDR);
            qcnt_d         = '0;
            state_d        = SCHED;
          end else if (io_take) begin
            // Timer stays frozen while the IO service runs.
            saved_d[pid_q] = seq_next;
            pc_d           = ADDR_W'(IO_ADDR);
            state_d        = IOSVC;
          end else begin
            pc_d = seq_next;
            if (qcnt_q != QMAX) qcnt_d = qcnt_q + QW'(1);
          end
        end
        SCHED: begin
          if (bus.ctx_ret) begin
            pid_d   = np_eff;
            pc_d    = saved_q[np_eff];
            qcnt_d  = '0;
            state_d = RUN;
          end else begin
            pc_d = seq_next;
          end
        end
        IOSVC: begin
          if (bus.ctx_ret) begin
            pc_d    = saved_q[pid_q];
            state_d = RUN;
          end else begin
            pc_d = seq_next;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      pid_q   <= '0;
      qcnt_q  <= '0;
      for (int i = 0; i < NPROC; i++) saved_q[i] <= ADDR_W'(i * PROC_STRIDE);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pid_q   <= pid_d;
      qcnt_q  <= qcnt_d;
      saved_q <= saved_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus1 = pc_plus1;
  assign bus.cur_pid  = pid_q;
  assign bus.in_sched = (state_q == SCHED);
endmodule

// File: tb/tb_pc_sequencer_ctx.sv
// Scoreboard bench for pc_sequencer_ctx: reference model pushes expected state per driven cycle,
// DUT outputs are popped and compared after each edge; a small 12-bit instance covers PC wrap.
module tb_pc_sequencer_ctx;
  localparam int QUANTUM = 8;
  localparam int NPROC   = 4;
  localparam int S_RUN = 0, S_SCHED = 1, S_IO = 2;

  logic clock;
  logic reset;

  pc_sequencer_ctx_if #(.ADDR_W(32), .IMM_W(11), .PID_W(2)) bus ();
  pc_sequencer_ctx_if #(.ADDR_W(12), .IMM_W(11), .PID_W(1)) sb ();

  pc_sequencer_ctx #(
    .ADDR_W(32), .IMM_W(11), .JR_W(26), .NPROC(NPROC), .QUANTUM(QUANTUM),
    .SCHED_ADDR(0), .IO_ADDR(512), .PROC_STRIDE(1024)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  pc_sequencer_ctx #(
    .ADDR_W(12), .IMM_W(11), .JR_W(8), .NPROC(2), .QUANTUM(4),
    .SCHED_ADDR(0), .IO_ADDR(512), .PROC_STRIDE(256)
  ) dut_small (
    .clock(clock), .reset(reset), .bus(sb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          halt_req, branch_take, jump_en, jump_reg_en, ctx_en, ctx_ret, io_trap;
    logic [10:0] imm;
    logic [31:0] rs_val;
    logic [1:0]  next_pid;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pid;
    bit          in_sched;
    bit          in_io;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  logic [31:0] m_pc;
  logic [1:0]  m_pid;
  int          m_state;
  int          m_q;
  logic [31:0] m_saved [NPROC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'd0;
    m_pid   = 2'd0;
    m_state = S_RUN;
    m_q     = 0;
    for (int i = 0; i < NPROC; i++) m_saved[i] = 32'(i * 1024);
  endtask

  task automatic model_step(input stim_t s);
    logic [31:0] nxt;
    int          np;
    if (s.jump_en) nxt = s.jump_reg_en ? {m_pc[31:26], s.rs_val[25:0]} : {m_pc[31:11], s.imm};
    else if (s.branch_take) nxt = {m_pc[31:11], s.imm};
    else nxt = m_pc + 32'd1;
    np = (int'(s.next_pid) < NPROC) ? int'(s.next_pid) : 0;
    if (!s.halt_req) begin
      if (m_state == S_RUN) begin
        if (m_q == QUANTUM - 1 && s.ctx_en) begin
          m_saved[m_pid] = nxt;
          m_pc = 32'd0; m_q = 0; m_state = S_SCHED;
        end
`ifdef PCSEQ_IO_TRAP_EN
        else if (s.io_trap) begin
          m_saved[m_pid] = nxt;
          m_pc = 32'd512; m_state = S_IO;
        end
`endif
        else begin
          m_pc = nxt;
          if (m_q < QUANTUM - 1) m_q++;
        end
      end else if (m_state == S_SCHED) begin
        if (s.ctx_ret) begin
          m_pid = 2'(np); m_pc = m_saved[np]; m_q = 0; m_state = S_RUN;
        end else m_pc = nxt;
      end else begin
        if (s.ctx_ret) begin
          m_pc = m_saved[m_pid]; m_state = S_RUN;
        end else m_pc = nxt;
      end
    end
  endtask

  function automatic stim_t idle(input bit ctx_en);
    stim_t s;
    s.halt_req = 0; s.branch_take = 0; s.jump_en = 0; s.jump_reg_en = 0;
    s.ctx_en = ctx_en; s.ctx_ret = 0; s.io_trap = 0;
    s.imm = '0; s.rs_val = '0; s.next_pid = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.halt_req    = ($urandom_range(0, 7) == 0);
    s.branch_take = ($urandom_range(0, 5) == 0);
    s.jump_en     = ($urandom_range(0, 6) == 0);
    s.jump_reg_en = $urandom_range(0, 1) == 1;
    s.ctx_en      = ($urandom_range(0, 3) != 0);
    s.ctx_ret     = ($urandom_range(0, 4) == 0);
    s.io_trap     = ($urandom_range(0, 5) == 0);
    s.imm         = 11'($urandom);
    s.rs_val      = $urandom;
    s.next_pid    = 2'($urandom_range(0, 3));
    return s;
  endfunction

  // Called just after a negedge; returns just after the following negedge.
  task automatic drive(input stim_t s);
    exp_t e;
    bus.halt_req = s.halt_req; bus.branch_take = s.branch_take;
    bus.jump_en = s.jump_en; bus.jump_reg_en = s.jump_reg_en;
    bus.imm = s.imm; bus.rs_val = s.rs_val; bus.ctx_en = s.ctx_en;
    bus.ctx_ret = s.ctx_ret; bus.next_pid = s.next_pid; bus.io_trap = s.io_trap;
    model_step(s);
    e.pc = m_pc; e.pid = m_pid; e.in_sched = (m_state == S_SCHED); e.in_io = (m_state == S_IO);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("pc", bus.pc, e.pc);
    check("pc_plus1", bus.pc_plus1, e.pc + 32'd1);
    check("cur_pid", 32'(bus.cur_pid), 32'(e.pid));
    check("in_sched", 32'(bus.in_sched), 32'(e.in_sched));
    check("in_io", 32'(bus.in_io), 32'(e.in_io));
    @(negedge clock);
  endtask

  stim_t s;

  initial begin
    reset = 1'b0;
    s = idle(1'b0);
    bus.halt_req = 0; bus.branch_take = 0; bus.jump_en = 0; bus.jump_reg_en = 0;
    bus.imm = '0; bus.rs_val = '0; bus.ctx_en = 0; bus.ctx_ret = 0; bus.next_pid = '0; bus.io_trap = 0;
    sb.halt_req = 0; sb.branch_take = 0; sb.jump_en = 0; sb.jump_reg_en = 0;
    sb.imm = '0; sb.rs_val = '0; sb.ctx_en = 0; sb.ctx_ret = 0; sb.next_pid = '0; sb.io_trap = 0;
    model_reset();
    #1;
    check("rst_pc", bus.pc, 32'd0);
    check("rst_pid", 32'(bus.cur_pid), 32'd0);
    check("rst_in_sched", 32'(bus.in_sched), 32'd0);
    check("rst_in_io", 32'(bus.in_io), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Small instance: branch into the top half and wrap past 0xFFF while the main DUT counts up.
    sb.branch_take = 1; sb.imm = 11'h7FF;
    drive(idle(1'b0));
    check("wrap_br_lo", 32'(sb.pc), 32'h7FF);
    sb.branch_take = 0;
    drive(idle(1'b0));
    check("wrap_carry", 32'(sb.pc), 32'h800);
    sb.branch_take = 1;
    drive(idle(1'b0));
    check("wrap_top", 32'(sb.pc), 32'hFFF);
    check("wrap_plus1", 32'(sb.pc_plus1), 32'h000);
    sb.branch_take = 0;
    drive(idle(1'b0));
    check("wrap_zero", 32'(sb.pc), 32'h000);
    drive(idle(1'b0));
    check("t2_pc5", bus.pc, 32'd5);

    // Branch and register jump
    s = idle(1'b0); s.branch_take = 1; s.imm = 11'h40;
    drive(s);
    check("t2_branch", bus.pc, 32'h40);
    s = idle(1'b0); s.jump_en = 1; s.jump_reg_en = 1; s.rs_val = 32'hFFFF_FF10;
    drive(s);
    check("t2_jr", bus.pc, 32'h03FF_FF10);

    // Quantum trap at pc=100, then return into process 1
    s = idle(1'b0); s.jump_en = 1; s.jump_reg_en = 1; s.rs_val = 32'd100;
    drive(s);
    check("t3_pc100", bus.pc, 32'd100);
    drive(idle(1'b1));
    check("t3_trap_pc", bus.pc, 32'd0);
    check("t3_trap_sched", 32'(bus.in_sched), 32'd1);
    drive(idle(1'b1));
    drive(idle(1'b1));
    s = idle(1'b1); s.ctx_ret = 1; s.next_pid = 2'd1;
    drive(s);
    check("t3_ret_pc", bus.pc, 32'd1024);
    check("t3_ret_pid", 32'(bus.cur_pid), 32'd1);
    for (int i = 0; i < QUANTUM - 1; i++) drive(idle(1'b1));
    check("t3_slice_run", 32'(bus.in_sched), 32'd0);
    drive(idle(1'b1));
    check("t3_slice_trap", 32'(bus.in_sched), 32'd1);
    s = idle(1'b0); s.ctx_ret = 1; s.next_pid = 2'd0;
    drive(s);
    check("t3_saved0", bus.pc, 32'd101);

    // Halt held across the trap boundary
    for (int i = 0; i < QUANTUM - 1; i++) drive(idle(1'b0));
    for (int i = 0; i < 20; i++) begin
      s = idle(1'b1); s.halt_req = 1; s.branch_take = 1; s.imm = 11'h3;
      s.ctx_ret = 1; s.io_trap = 1;
      drive(s);
    end
    check("t4_halt_pc", bus.pc, 32'd108);
    check("t4_halt_state", 32'(bus.in_sched), 32'd0);
    drive(idle(1'b1));
    check("t4_trap_pc", bus.pc, 32'd0);
    check("t4_trap_sched", 32'(bus.in_sched), 32'd1);
    s = idle(1'b0); s.ctx_ret = 1; s.next_pid = 2'd0;
    drive(s);
    check("t4_saved0", bus.pc, 32'd109);

`ifdef PCSEQ_IO_TRAP_EN
    for (int i = 0; i < QUANTUM - 1; i++) drive(idle(1'b0));
    s = idle(1'b1); s.io_trap = 1;
    drive(s);
    check("t5_quantum_wins", 32'(bus.in_sched), 32'd1);
    check("t5_no_io", 32'(bus.in_io), 32'd0);
    s = idle(1'b1); s.io_trap = 1; s.ctx_ret = 1; s.next_pid = 2'd3;
    drive(s);
    check("t5_ret_pc", bus.pc, 32'd3072);
    s = idle(1'b1); s.io_trap = 1;
    drive(s);
    check("t5_io_pc", bus.pc, 32'd512);
    check("t5_in_io", 32'(bus.in_io), 32'd1);
    drive(idle(1'b1));
    check("t5_io_step", bus.pc, 32'd513);
    s = idle(1'b1); s.ctx_ret = 1; s.next_pid = 2'd1;
    drive(s);
    check("t5_io_ret_pc", bus.pc, 32'd3073);
    check("t5_io_ret_pid", 32'(bus.cur_pid), 32'd3);
`else
    for (int i = 0; i < 50; i++) begin
      s = idle(1'b0); s.io_trap = 1;
      drive(s);
    end
    check("t6_pc", bus.pc, 32'd159);
    check("t6_in_io", 32'(bus.in_io), 32'd0);
`endif

    for (int i = 0; i < 400; i++) drive(rnd());

    // Async reset mid-run
    s = idle(1'b0); s.jump_en = 1; s.jump_reg_en = 1; s.rs_val = 32'd37;
    drive(s);
    check("t1_pc37", bus.pc, 32'd37);
    #2 reset = 1'b0;
    #1;
    check("t1_async_pc", bus.pc, 32'd0);
    check("t1_async_pid", 32'(bus.cur_pid), 32'd0);
    check("t1_async_sched", 32'(bus.in_sched), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < QUANTUM; i++) drive(idle(1'b1));
    check("t1_trap_after_rst", 32'(bus.in_sched), 32'd1);
    s = idle(1'b0); s.ctx_ret = 1; s.next_pid = 2'd2;
    drive(s);
    check("t1_saved2", bus.pc, 32'd2048);
    check("t1_pid2", 32'(bus.cur_pid), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
